// File: rtl/match_controller.sv
// ---------------------------------------------------------------------------
// match_controller
//   Frame-paced match sequencer for the two-player paddle game. It takes
//   ball-miss events from the collision evaluator and owns both score
//   registers. It drives the round-reset line for the ball and paddles, and
//   the overlay enables for the point and match-over graphics.
//
// Ports
//   pixel_clk  in   pixel clock
//   rst        in   synchronous, active-high reset
//   fsync      in   one-cycle pulse at the start of each frame
//   start      in   start/restart button level (already synchronised)
//   miss_top   in   one-cycle pulse: ball passed top paddle (point to P2)
//   miss_bot   in   one-cycle pulse: ball passed bottom paddle (point to P1)
//   play_rst   out  holds ball and paddles in reset
//   point_show out  point overlay enable
//   match_show out  match-over overlay enable
//   p1_score   out  player 1 score (4 bit)
//   p2_score   out  player 2 score (4 bit)
//   winner     out  00 none, 01 player 1, 10 player 2
//   state_out  out  current state encoding (debug)
//
// Every output comes straight from a register. The registered overlay and
// reset enables are computed from the next state. As a result, they change
// on the same edge as the state register.
// ---------------------------------------------------------------------------
module match_controller #(
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60,
  parameter int PAUSE_FRAMES = 128
) (
  input  logic       pixel_clk,
  input  logic       rst,
  input  logic       fsync,
  input  logic       start,
  input  logic       miss_top,
  input  logic       miss_bot,
  output logic       play_rst,
  output logic       point_show,
  output logic       match_show,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [1:0] winner,
  output logic [2:0] state_out
);

  localparam int MAX_FRAMES = (SERVE_FRAMES > PAUSE_FRAMES) ? SERVE_FRAMES : PAUSE_FRAMES;
  localparam int CNT_W      = $clog2(MAX_FRAMES + 1);

  // The counter value seen on the fsync that completes the wait. The
  // increment to SERVE_FRAMES/PAUSE_FRAMES is replaced by the state exit.
  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0] PAUSE_LAST = CNT_W'(PAUSE_FRAMES - 1);
  localparam logic [3:0]       WIN        = 4'(WIN_SCORE);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SERVE      = 3'd1,
    ST_PLAY       = 3'd2,
    ST_POINT      = 3'd3,
    ST_MATCH_OVER = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       p1_q, p1_d;
  logic [3:0]       p2_q, p2_d;
  logic [1:0]       winner_q, winner_d;
  logic             play_rst_q, play_rst_d;
  logic             point_show_q, point_show_d;
  logic             match_show_q, match_show_d;
  logic             start_q;

  // Next-state, frame counter and score update logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    winner_d = winner_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = {CNT_W{1'b0}};
        if (start) begin
          state_d = ST_SERVE;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SERVE: begin
        if (fsync) begin
          if (cnt_q == SERVE_LAST) begin
            state_d = ST_PLAY;
            cnt_d   = {CNT_W{1'b0}};
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end

      ST_PLAY: begin
        // The counter is idle in PLAY. This also covers an fsync that
        // lands on the same cycle as a miss.
        cnt_d = {CNT_W{1'b0}};
        if (miss_top && miss_bot) begin
          state_d = ST_SERVE;
        end else if (miss_bot) begin
          p1_d    = p1_q + 4'd1;
          state_d = ST_POINT;
        end else if (miss_top) begin
          p2_d    = p2_q + 4'd1;
          state_d = ST_POINT;
        end else begin
          state_d = ST_PLAY;
        end
      end

      ST_POINT: begin
        if (fsync) begin
          if (cnt_q == PAUSE_LAST) begin
            cnt_d = {CNT_W{1'b0}};
            if (p1_q == WIN) begin
              state_d  = ST_MATCH_OVER;
              winner_d = 2'b01;
            end else if (p2_q == WIN) begin
              state_d  = ST_MATCH_OVER;
              winner_d = 2'b10;
            end else begin
              state_d = ST_SERVE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end

      ST_MATCH_OVER: begin
        cnt_d = {CNT_W{1'b0}};
        // Only a fresh press restarts the match. Holding start through the
        // pause does not restart it.
        if (start && !start_q) begin
          p1_d     = 4'd0;
          p2_d     = 4'd0;
          winner_d = 2'b00;
          state_d  = ST_SERVE;
        end else begin
          state_d = ST_MATCH_OVER;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase

    play_rst_d   = (state_d != ST_PLAY);
    point_show_d = (state_d == ST_POINT);
    match_show_d = (state_d == ST_MATCH_OVER);
  end

  // State, counter, score and registered-output flops with synchronous reset.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      p1_q         <= 4'd0;
      p2_q         <= 4'd0;
      winner_q     <= 2'b00;
      play_rst_q   <= 1'b1;
      point_show_q <= 1'b0;
      match_show_q <= 1'b0;
      start_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      p1_q         <= p1_d;
      p2_q         <= p2_d;
      winner_q     <= winner_d;
      play_rst_q   <= play_rst_d;
      point_show_q <= point_show_d;
      match_show_q <= match_show_d;
      start_q      <= start;
    end
  end

  assign play_rst   = play_rst_q;
  assign point_show = point_show_q;
  assign match_show = match_show_q;
  assign p1_score   = p1_q;
  assign p2_score   = p2_q;
  assign winner     = winner_q;
  assign state_out  = state_q;

endmodule

// File: tb/tb_match_controller.sv
// ---------------------------------------------------------------------------
// tb_match_controller
//   Directed testbench for match_controller with its default parameters
//   (WIN_SCORE=9, SERVE_FRAMES=60, PAUSE_FRAMES=128). A frame is two clock
//   cycles: one fsync cycle followed by one quiet cycle. Inputs change and
//   outputs are sampled 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_match_controller;

  logic       pixel_clk = 1'b0;
  logic       rst = 1'b1;
  logic       fsync = 1'b0;
  logic       start = 1'b0;
  logic       miss_top = 1'b0;
  logic       miss_bot = 1'b0;
  logic       play_rst;
  logic       point_show;
  logic       match_show;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic [1:0] winner;
  logic [2:0] state_out;

  int errors = 0;
  int checks = 0;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SERVE = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_POINT = 3'd3;
  localparam logic [2:0] S_MATCH = 3'd4;

  match_controller dut (
    .pixel_clk  (pixel_clk),
    .rst        (rst),
    .fsync      (fsync),
    .start      (start),
    .miss_top   (miss_top),
    .miss_bot   (miss_bot),
    .play_rst   (play_rst),
    .point_show (point_show),
    .match_show (match_show),
    .p1_score   (p1_score),
    .p2_score   (p2_score),
    .winner     (winner),
    .state_out  (state_out)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      fsync = 1'b1;
      tick();
      fsync = 1'b0;
      tick();
    end
  endtask

  task automatic chk_state(input string tag, input logic [2:0] exp);
    chk(tag, {5'd0, state_out}, {5'd0, exp});
  endtask

  initial begin
    // Reset values
    repeat (3) tick();
    rst = 1'b0;
    chk_state("reset_state", S_IDLE);
    chk("reset_play_rst", {7'd0, play_rst}, 8'd1);
    chk("reset_point_show", {7'd0, point_show}, 8'd0);
    chk("reset_match_show", {7'd0, match_show}, 8'd0);
    chk("reset_p1", {4'd0, p1_score}, 8'd0);
    chk("reset_p2", {4'd0, p2_score}, 8'd0);
    chk("reset_winner", {6'd0, winner}, 8'd0);

    // IDLE holds without start
    frames(5);
    chk_state("idle_no_start", S_IDLE);
    chk("idle_play_rst", {7'd0, play_rst}, 8'd1);

    // Start -> SERVE, exits on the 60th fsync
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_state("start_to_serve", S_SERVE);
    frames(59);
    chk_state("serve_frame59", S_SERVE);
    chk("serve_play_rst", {7'd0, play_rst}, 8'd1);
    frames(1);
    chk_state("serve_to_play", S_PLAY);
    chk("play_rst_low", {7'd0, play_rst}, 8'd0);

    // miss_bot: point to player 1, one cycle latency
    miss_bot = 1'b1;
    tick();
    miss_bot = 1'b0;
    chk("missbot_p1", {4'd0, p1_score}, 8'd1);
    chk("missbot_point_show", {7'd0, point_show}, 8'd1);
    chk_state("missbot_state", S_POINT);
    chk("point_play_rst", {7'd0, play_rst}, 8'd1);
    frames(127);
    chk_state("point_frame127", S_POINT);
    frames(1);
    chk_state("point_to_serve", S_SERVE);
    chk("serve_point_show", {7'd0, point_show}, 8'd0);
    frames(60);
    chk_state("reserve_to_play", S_PLAY);

    // Simultaneous misses -> replay, no score
    miss_top = 1'b1;
    miss_bot = 1'b1;
    tick();
    miss_top = 1'b0;
    miss_bot = 1'b0;
    chk_state("both_state", S_SERVE);
    chk("both_p1", {4'd0, p1_score}, 8'd1);
    chk("both_p2", {4'd0, p2_score}, 8'd0);
    chk("both_point_show", {7'd0, point_show}, 8'd0);
    frames(60);
    chk_state("both_back_play", S_PLAY);

    // Bring player 2 to 8 points
    for (int k = 0; k < 8; k++) begin
      miss_top = 1'b1;
      tick();
      miss_top = 1'b0;
      frames(128);
      frames(60);
    end
    chk("p2_eight", {4'd0, p2_score}, 8'd8);
    chk_state("p2_eight_play", S_PLAY);

    // Winning miss coincides with fsync: counter cleared, not incremented
    miss_top = 1'b1;
    fsync = 1'b1;
    tick();
    miss_top = 1'b0;
    fsync = 1'b0;
    tick();
    chk("p2_nine", {4'd0, p2_score}, 8'd9);
    chk_state("win_point", S_POINT);
    frames(100);
    start = 1'b1;          // raised during POINT, must be ignored
    frames(27);
    chk_state("start_ignored_point", S_POINT);
    frames(1);
    chk_state("match_over", S_MATCH);
    chk("winner_p2", {6'd0, winner}, 8'd2);
    chk("match_show_on", {7'd0, match_show}, 8'd1);
    chk("match_point_show", {7'd0, point_show}, 8'd0);
    chk("match_play_rst", {7'd0, play_rst}, 8'd1);

    // Misses ignored in MATCH_OVER; held start does not restart
    miss_bot = 1'b1;
    tick();
    miss_bot = 1'b0;
    miss_top = 1'b1;
    tick();
    miss_top = 1'b0;
    repeat (3) tick();
    chk("frozen_p1", {4'd0, p1_score}, 8'd1);
    chk("frozen_p2", {4'd0, p2_score}, 8'd9);
    chk_state("held_start_stays", S_MATCH);

    // Start low then high -> new match
    start = 1'b0;
    tick();
    chk_state("start_low_stays", S_MATCH);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_state("restart_serve", S_SERVE);
    chk("restart_p1", {4'd0, p1_score}, 8'd0);
    chk("restart_p2", {4'd0, p2_score}, 8'd0);
    chk("restart_winner", {6'd0, winner}, 8'd0);
    chk("restart_match_show", {7'd0, match_show}, 8'd0);

    // Reset in the middle of a POINT pause
    frames(60);
    miss_bot = 1'b1;
    tick();
    miss_bot = 1'b0;
    frames(40);
    chk_state("mid_point", S_POINT);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_state("rst_idle", S_IDLE);
    chk("rst_p1", {4'd0, p1_score}, 8'd0);
    chk("rst_point_show", {7'd0, point_show}, 8'd0);
    chk("rst_play_rst", {7'd0, play_rst}, 8'd1);
    chk("rst_counter", 8'(dut.cnt_q), 8'd0);

    // Miss in IDLE is ignored
    miss_bot = 1'b1;
    tick();
    miss_bot = 1'b0;
    tick();
    chk("idle_miss_p1", {4'd0, p1_score}, 8'd0);
    chk_state("idle_miss_state", S_IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/match_controller.md
Name: match_controller

Overview:
- Frame-paced game sequencer for the two-player paddle game. Replaces the ad-hoc game-over/score logic.
- Consumes ball-miss events from the collision evaluator and owns both score registers.
- Drives the round-reset line for the ball and paddles, and the overlay enables for the game-over and match-over graphics.
- Sits between the video timing (fsync) and the object/paddle/scoreboard blocks.

Parameters:
WIN_SCORE, 9, score value that ends the match (1..15)
SERVE_FRAMES, 60, frames play_rst is held before each serve (>=1)
PAUSE_FRAMES, 128, frames the point overlay is shown after a miss (>=1)

Ports:
pixel_clk  in  1  pixel clock
rst  in  1  synchronous active-high reset
fsync  in  1  one-cycle pulse at start of each frame
start  in  1  level, user start/restart button (already synchronised)
miss_top  in  1  one-cycle pulse: ball passed top paddle (point to player 2)
miss_bot  in  1  one-cycle pulse: ball passed bottom paddle (point to player 1)
play_rst  out  1  holds ball and paddles in reset
point_show  out  1  point/game-over overlay enable
match_show  out  1  match-over overlay enable
p1_score  out  4  player 1 score
p2_score  out  4  player 2 score
winner  out  2  00 none, 01 player 1, 10 player 2
state_out  out  3  current state encoding, for debug

Behaviour:
- Decided interface: reset rst, synchronous, active-high; clock pixel_clk.
- All outputs are registered.
- Reset values: state IDLE, play_rst=1, point_show=0, match_show=0, scores 0, winner 00, frame counter 0.
- State encodings: IDLE=0, SERVE=1, PLAY=2, POINT=3, MATCH_OVER=4.
- IDLE: play_rst=1. When start=1 → SERVE, counter cleared.
- SERVE: play_rst=1. Counter increments on each fsync. On the fsync that brings the counter to SERVE_FRAMES → PLAY, counter cleared, play_rst=0 from the next cycle.
- PLAY: play_rst=0.
  - miss_bot alone: p1_score+1 on the transition cycle, → POINT.
  - miss_top alone: p2_score+1, → POINT.
  - Both in the same cycle: no score change, → SERVE (replay).
  - Latency: the score register and point_show update 1 cycle after the miss pulse.
- POINT: play_rst=1, point_show=1. Counter increments on fsync. On reaching PAUSE_FRAMES:
  - if either score == WIN_SCORE → MATCH_OVER, winner set to the player at WIN_SCORE, point_show=0, match_show=1.
  - else → SERVE.
- MATCH_OVER: play_rst=1, match_show=1, scores frozen.
  - start must be seen low then high (rising edge, tracked by a registered start_q) → both scores cleared, winner=00, → SERVE.
  - A start held high throughout the pause does not skip MATCH_OVER.
- Miss pulses outside PLAY are ignored, with no score change.
- fsync coinciding with a miss in PLAY: the miss is handled and the counter is cleared, not incremented.
- Scores never exceed WIN_SCORE, so there is no 4-bit wrap. Score compare is unsigned 4-bit.
- Frame counter width is clog2(max(SERVE_FRAMES, PAUSE_FRAMES)+1). It saturates only via state exit.
- rst asserted in any state returns to the reset values on the next edge, including mid-pause and mid-serve.
- start is ignored in SERVE, PLAY and POINT.

Test Plan:
- Reset, hold start=0 for 5 frames → state IDLE, play_rst=1, scores 0. Pulse start → SERVE; after 60 fsyncs → PLAY, play_rst=0 one cycle later.
- In PLAY, pulse miss_bot → next cycle p1_score=1, point_show=1. After 128 fsyncs → SERVE, point_show=0, then PLAY after 60 more.
- In PLAY, pulse miss_top and miss_bot in the same cycle → scores unchanged, state SERVE, point_show=0.
- Drive p2_score to 8, then miss_top → p2_score=9, POINT. After 128 frames → MATCH_OVER, winner=10, match_show=1. Further misses are ignored.
- In MATCH_OVER with start held high → stays. Drop start, raise it → scores 0, winner 00, SERVE.
- Assert rst mid-POINT (frame 40) → next cycle IDLE, scores 0, point_show=0, counter 0. Pulse miss_bot in IDLE → no change.
